// File: rtl/ipv4_rx_decoder.sv
// IPv4 receive header decoder: validates the header, strips header and options,
// and forwards the payload (UDP segment) with start/fin markers plus the
// addresses and payload length used by the downstream UDP pseudo-header.
module ipv4_rx_decoder #(
  parameter logic [7:0]  PROTOCOL    = 8'd17,
  parameter logic [15:0] MIN_PAYLOAD = 16'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data,
  output logic [31:0] src_ip,
  output logic [31:0] dest_ip,
  output logic [15:0] len_udp,
  output logic [31:0] data_out,
  output logic        start_out,
  output logic        valid_out,
  output logic        fin,
  output logic        ok,
  output logic        err
);

  localparam int unsigned ACC_W = 21;  // 15 header words x 2 halves x 16 bits fits
  localparam int unsigned CNT_W = 15;  // ceil(65535 / 4) payload words
  localparam int unsigned LEN_W = 17;  // length compares without overflow

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [3:0]       ihl_q, ihl_d;
  logic [15:0]      tlen_q, tlen_d;
  logic             ver_bad_q, ver_bad_d;
  logic             frag_bad_q, frag_bad_d;
  logic             proto_bad_q, proto_bad_d;
  logic [ACC_W-1:0] csum_q, csum_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             first_q, first_d;

  logic [31:0]      src_ip_d, dest_ip_d, data_out_d;
  logic [15:0]      len_udp_d;
  logic             start_out_d, valid_out_d, fin_d, ok_d, err_d;

  logic [ACC_W-1:0] sum_w;
  logic [16:0]      fold1;
  logic [15:0]      fold2;
  logic [LEN_W-1:0] hdr_bytes;
  logic [LEN_W-1:0] tlen_ext;
  logic [15:0]      pay_len;
  logic [CNT_W-1:0] pay_words;
  logic             hdr_bad;
  logic [31:0]      last_mask;

  // Next-state, header checks and output computation
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    ihl_d       = ihl_q;
    tlen_d      = tlen_q;
    ver_bad_d   = ver_bad_q;
    frag_bad_d  = frag_bad_q;
    proto_bad_d = proto_bad_q;
    csum_d      = csum_q;
    pcnt_d      = pcnt_q;
    first_d     = first_q;
    src_ip_d    = src_ip;
    dest_ip_d   = dest_ip;
    len_udp_d   = len_udp;
    data_out_d  = data_out;
    ok_d        = ok;
    start_out_d = 1'b0;
    valid_out_d = 1'b0;
    fin_d       = 1'b0;
    err_d       = 1'b0;

    // Running checksum including the current word, folded twice at the end
    sum_w     = csum_q + ACC_W'(data[31:16]) + ACC_W'(data[15:0]);
    fold1     = 17'(sum_w[15:0]) + 17'(sum_w[ACC_W-1:16]);
    fold2     = fold1[15:0] + 16'(fold1[16]);
    hdr_bytes = LEN_W'({ihl_q, 2'b00});
    tlen_ext  = LEN_W'(tlen_q);
    pay_len   = tlen_q - 16'({ihl_q, 2'b00});
    pay_words = CNT_W'((LEN_W'(pay_len) + LEN_W'(3)) >> 2);
    hdr_bad   = ver_bad_q | frag_bad_q | proto_bad_q | (fold2 != 16'hFFFF) |
                (tlen_ext < hdr_bytes + LEN_W'(MIN_PAYLOAD));

    // Keep only the valid byte lanes of the final payload word
    case (len_udp[1:0])
      2'd1:    last_mask = 32'hFF00_0000;
      2'd2:    last_mask = 32'hFFFF_0000;
      2'd3:    last_mask = 32'hFFFF_FF00;
      default: last_mask = 32'hFFFF_FFFF;
    endcase

    if (start) begin
      // Any start begins a new packet; an in-flight one is dropped silently
      ok_d        = 1'b0;
      ihl_d       = data[27:24];
      tlen_d      = data[15:0];
      ver_bad_d   = (data[31:28] != 4'd4);
      frag_bad_d  = 1'b0;
      proto_bad_d = 1'b0;
      csum_d      = ACC_W'(data[31:16]) + ACC_W'(data[15:0]);
      wcnt_d      = 4'd1;
      if (data[27:24] < 4'd5) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        state_d = HEADER;
      end
    end else begin
      case (state_q)
        IDLE: begin
        end
        HEADER: begin
          csum_d = sum_w;
          wcnt_d = wcnt_q + 4'd1;
          case (wcnt_q)
            4'd1:    frag_bad_d  = data[13] | (data[12:0] != 13'd0);
            4'd2:    proto_bad_d = (data[23:16] != PROTOCOL);
            4'd3:    src_ip_d    = data;
            4'd4:    dest_ip_d   = data;
            default: ;
          endcase
          if (wcnt_q == ihl_q - 4'd1) begin
            if (!hdr_bad) begin
              ok_d      = 1'b1;
              len_udp_d = pay_len;
              pcnt_d    = pay_words;
              first_d   = 1'b1;
              state_d   = PAYLOAD;
            end else begin
              ok_d  = 1'b0;
              err_d = 1'b1;
              if (tlen_ext >= hdr_bytes && pay_words != CNT_W'(0)) begin
                pcnt_d  = pay_words;
                state_d = DROP;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        PAYLOAD: begin
          valid_out_d = 1'b1;
          start_out_d = first_q;
          first_d     = 1'b0;
          data_out_d  = data;
          pcnt_d      = pcnt_q - CNT_W'(1);
          if (pcnt_q == CNT_W'(1)) begin
            fin_d      = 1'b1;
            data_out_d = data & last_mask;
            state_d    = IDLE;
          end
        end
        DROP: begin
          pcnt_d = pcnt_q - CNT_W'(1);
          if (pcnt_q == CNT_W'(1)) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      ihl_q       <= '0;
      tlen_q      <= '0;
      ver_bad_q   <= 1'b0;
      frag_bad_q  <= 1'b0;
      proto_bad_q <= 1'b0;
      csum_q      <= '0;
      pcnt_q      <= '0;
      first_q     <= 1'b0;
      src_ip      <= '0;
      dest_ip     <= '0;
      len_udp     <= '0;
      data_out    <= '0;
      start_out   <= 1'b0;
      valid_out   <= 1'b0;
      fin         <= 1'b0;
      ok          <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      ihl_q       <= ihl_d;
      tlen_q      <= tlen_d;
      ver_bad_q   <= ver_bad_d;
      frag_bad_q  <= frag_bad_d;
      proto_bad_q <= proto_bad_d;
      csum_q      <= csum_d;
      pcnt_q      <= pcnt_d;
      first_q     <= first_d;
      src_ip      <= src_ip_d;
      dest_ip     <= dest_ip_d;
      len_udp     <= len_udp_d;
      data_out    <= data_out_d;
      start_out   <= start_out_d;
      valid_out   <= valid_out_d;
      fin         <= fin_d;
      ok          <= ok_d;
      err         <= err_d;
    end
  end

endmodule

// File: doc/ipv4_rx_decoder.md
Name: ipv4_rx_decoder

Overview:
Receive-side IPv4 header decoder that sits directly upstream of the UDP decoder. It takes a 32-bit word stream that starts at the IPv4 header and checks version, IHL, fragmentation, protocol and header checksum. It strips the header and any options, then forwards the payload (the UDP segment) with a one-cycle start marker. It also presents src_ip, dest_ip and len_udp, which the UDP decoder uses for its pseudo-header.

Parameters:
PROTOCOL, 8'd17, required IPv4 protocol field; any other value is rejected.
MIN_PAYLOAD, 16'd8, minimum accepted payload length in bytes (the UDP header size).

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  high for one cycle together with header word 0
data  in  32  input word, big-endian (byte 0 in [31:24]); one word per cycle, no gaps, from start until the packet ends
src_ip  out  32  source address from header word 3
dest_ip  out  32  destination address from header word 4
len_udp  out  16  total_length − IHL*4, in bytes
data_out  out  32  payload word
start_out  out  1  high with payload word 0 only
valid_out  out  1  high while data_out holds a payload word
fin  out  1  high with the last payload word
ok  out  1  level; header accepted for the current packet
err  out  1  one-cycle pulse; header rejected

Behaviour:
- Reset: all outputs 0, state IDLE, accumulators and counters cleared. Reset overrides start in the same cycle and aborts any packet mid-operation with no fin or err.
- States:
  - IDLE: start=1 captures word 0 and goes to HEADER, word count 1.
  - HEADER: capture header words 1..IHL*4/4−1.
  - PAYLOAD: forward payload words.
  - DROP: consume remaining words silently.
- Header field capture:
  - Word 0: version [31:28], IHL [27:24], total_length [15:0].
  - Word 1: MF = [13], fragment offset = [12:0].
  - Word 2: protocol [23:16].
  - Words 3 and 4: src_ip and dest_ip, registered on capture.
  - Option words: summed into the checksum, otherwise ignored.
- Checksum:
  - Add both 16-bit halves of every header word into a 21-bit accumulator.
  - At the last header word, fold the accumulator to 16 bits twice.
  - Good when the folded sum equals 16'hFFFF.
- Accept/reject decision is made on the edge that samples the last header word. Reject if any of:
  - version≠4
  - IHL<5
  - MF=1 or offset≠0
  - protocol≠PROTOCOL
  - checksum bad
  - total_length < IHL*4 + MIN_PAYLOAD
- Accept: ok<=1, len_udp registered, go to PAYLOAD with payload word count = ceil(len_udp/4).
- Reject: err pulses for 1 cycle, ok<=0.
  - If total_length ≥ IHL*4, go to DROP for ceil((total_length−IHL*4)/4) words, otherwise straight to IDLE.
  - If IHL<5, go to IDLE immediately after word 0, with err in the following cycle.
- Payload latency: 1 cycle. The edge that samples payload word i registers data_out<=data and valid_out<=1. It also sets start_out<=(i==0) and fin<=(i==last).
- Last payload word: byte lanes beyond len_udp are forced to 8'h00 on data_out. Valid bytes in the last word = len_udp mod 4, where 0 means all four bytes are valid.
- After the last word: the next cycle returns valid_out, start_out and fin to 0, and the state to IDLE. src_ip, dest_ip, len_udp and ok hold until the next start or reset.
- start in HEADER, PAYLOAD or DROP: abort the current packet silently (no fin or err), clear ok and treat the word as header word 0.
- Single-word payload: start_out and fin are both high in the same cycle.

Test Plan:
1. Good packet. Words 45000027, 1C460000, 40119D0A, 9801331B, 980E5E4B, then payload A08F2694, 00132560, 48656C6C ("Hell"), 6F20576F, 726C64xx.
   Required: src_ip=9801331B, dest_ip=980E5E4B, len_udp=0x0013, ok=1.
   Required: 5 output words, each 1 cycle after its input word, start_out on A08F2694, fin on 726C6400 (low byte masked), err=0.
2. Same packet with checksum 9D0B -> err pulses 1 cycle after word 4, ok=0, no valid_out during the following 5 words, then IDLE.
3. Protocol 0x06 (word 2 = 40069D15) or MF=1 (word 1 = 1C462000) -> err pulse, payload dropped, ok=0.
4. IHL=6, one option word 00000000, total_length 0x002B, checksum recomputed -> option skipped, len_udp=0x0013, same 5-word payload output as scenario 1.
5. Reset for 1 cycle during payload word 2 -> all outputs 0 next cycle, no fin. A following good packet decodes exactly as in scenario 1.
6. start reasserted during header word 3 -> first packet aborted with no err or fin; the new packet decodes correctly.
